// File: rtl/multi_tone_dds_if.sv
// Control, config-write and sample-output bundle of the multi-tone DDS.
interface multi_tone_dds_if #(
    parameter int SIG_WIDTH = 16,
    parameter int NUM_TONES = 8
);
    localparam int NT_W  = $clog2(NUM_TONES + 1);
    localparam int IDX_W = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1;

    logic                 i_start;
    logic [NT_W-1:0]      i_num_tones;
    logic                 i_wr_en;
    logic [1:0]           i_wr_sel;
    logic [IDX_W-1:0]     i_wr_idx;
    logic [31:0]          i_wr_data;
    logic                 i_sample_en;
    logic [SIG_WIDTH-1:0] o_dds_signal;
    logic                 o_dds_valid;
    logic                 o_busy;
    logic                 o_overrun;
    logic                 o_wr_drop;

    modport master (
        output i_start, i_num_tones, i_wr_en, i_wr_sel,
        output i_wr_idx, i_wr_data, i_sample_en,
        input  o_dds_signal, o_dds_valid, o_busy,
        input  o_overrun, o_wr_drop
    );

    modport slave (
        input  i_start, i_num_tones, i_wr_en, i_wr_sel,
        input  i_wr_idx, i_wr_data, i_sample_en,
        output o_dds_signal, o_dds_valid, o_busy,
        output o_overrun, o_wr_drop
    );
endinterface

// File: rtl/multi_tone_dds.sv
// Multi-tone DDS: N phase accumulators time-shared over one sine LUT and multiplier.
// Optional output saturation: define DDS_SAT_EN (default wraps to SIG_WIDTH bits).
module multi_tone_dds #(
    parameter int SIG_WIDTH      = 16,
    parameter int PHASE_WIDTH    = 32,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int NUM_TONES      = 8
) (
    input logic             clk,
    input logic             rst,
    multi_tone_dds_if.slave bus
);
    localparam int NT_W      = $clog2(NUM_TONES + 1);
    localparam int IDX_W     = (NUM_TONES > 1) ? $clog2(NUM_TONES) : 1;
    localparam int LUT_DEPTH = 1 << LUT_ADDR_WIDTH;
    localparam int PROD_W    = 2 * SIG_WIDTH;
    localparam int ACC_W     = PROD_W + $clog2(NUM_TONES);

    function automatic logic [LUT_DEPTH*SIG_WIDTH-1:0] gen_lut();
        logic [LUT_DEPTH*SIG_WIDTH-1:0] t;
        real amp;
        real v;
        int  r;
        t   = '0;
        amp = real'((1 << (SIG_WIDTH - 1)) - 1);
        for (int k = 0; k < LUT_DEPTH; k++) begin
            v = amp * $sin(2.0 * 3.14159265358979 * real'(k) / real'(LUT_DEPTH));
            r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
            t[k*SIG_WIDTH +: SIG_WIDTH] = r[SIG_WIDTH-1:0];
        end
        return t;
    endfunction

    localparam logic [LUT_DEPTH*SIG_WIDTH-1:0] SINE = gen_lut();

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    logic signed [SIG_WIDTH-1:0] lut [LUT_DEPTH];

    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
        assign lut[g] = SINE[g*SIG_WIDTH +: SIG_WIDTH];
    end

    state_t                      state;
    logic [PHASE_WIDTH-1:0]      theta [NUM_TONES];
    logic [PHASE_WIDTH-1:0]      delta [NUM_TONES];
    logic signed [SIG_WIDTH-1:0] ampl  [NUM_TONES];
    logic [NT_W-1:0]             n_q;
    logic [NT_W-1:0]             k;
    logic [1:0]                  dcnt;
    logic                        iss_v;
    logic                        prod_v;
    logic signed [SIG_WIDTH-1:0] sin_q;
    logic signed [SIG_WIDTH-1:0] amp_q;
    logic signed [PROD_W-1:0]    prod_q;
    logic signed [ACC_W-1:0]     acc;
    logic                        busy;
    logic                        overrun;
    logic                        idx_ok;
    logic [NT_W-1:0]             n_in;
    logic [IDX_W-1:0]            kt;
    logic                        last;
    logic signed [SIG_WIDTH-1:0] reduced;

    if ((1 << IDX_W) > NUM_TONES) begin : g_idx_chk
        assign idx_ok = 32'(bus.i_wr_idx) < NUM_TONES;
    end else begin : g_idx_all
        assign idx_ok = 1'b1;
    end

    assign n_in = (32'(bus.i_num_tones) > NUM_TONES) ? NT_W'(NUM_TONES)
                                                      : bus.i_num_tones;
    assign kt   = k[IDX_W-1:0];
    assign last = (k == n_q - NT_W'(1));

`ifdef DDS_SAT_EN
    localparam logic signed [ACC_W-1:0] S_MAX = ACC_W'((1 << (SIG_WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] S_MIN = ~S_MAX;

    logic signed [ACC_W-1:0] shifted;
    assign shifted = acc >>> (SIG_WIDTH - 1);

    always_comb begin
        reduced = shifted[SIG_WIDTH-1:0];
        if (shifted > S_MAX)
            reduced = S_MAX[SIG_WIDTH-1:0];
        else if (shifted < S_MIN)
            reduced = S_MIN[SIG_WIDTH-1:0];
    end
`else
    assign reduced = SIG_WIDTH'(acc >>> (SIG_WIDTH - 1));
`endif

    assign bus.o_busy    = busy;
    assign bus.o_overrun = overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            for (int i = 0; i < NUM_TONES; i++) begin
                theta[i] <= '0;
                delta[i] <= '0;
                ampl[i]  <= '0;
            end
            n_q              <= '0;
            k                <= '0;
            dcnt             <= '0;
            iss_v            <= 1'b0;
            prod_v           <= 1'b0;
            sin_q            <= '0;
            amp_q            <= '0;
            prod_q           <= '0;
            acc              <= '0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
            bus.o_dds_signal <= '0;
            bus.o_dds_valid  <= 1'b0;
            bus.o_wr_drop    <= 1'b0;
        end else begin
            bus.o_dds_valid <= 1'b0;
            bus.o_wr_drop   <= bus.i_wr_en && busy;
            if (bus.i_sample_en && busy)
                overrun <= 1'b1;
            if (bus.i_wr_en && !busy && idx_ok) begin
                unique case (bus.i_wr_sel)
                    2'd0:    theta[bus.i_wr_idx] <= bus.i_wr_data[PHASE_WIDTH-1:0];
                    2'd1:    delta[bus.i_wr_idx] <= bus.i_wr_data[PHASE_WIDTH-1:0];
                    2'd2:    ampl[bus.i_wr_idx]  <= bus.i_wr_data[SIG_WIDTH-1:0];
                    default: ;
                endcase
            end
            // product and accumulate stages run freely behind the issue stage
            iss_v  <= 1'b0;
            prod_v <= iss_v;
            prod_q <= amp_q * sin_q;
            if (prod_v)
                acc <= acc + ACC_W'(prod_q);
            unique case (state)
                IDLE: begin
                    if (bus.i_sample_en && bus.i_start) begin
                        n_q   <= n_in;
                        k     <= '0;
                        dcnt  <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= (n_in == '0) ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    iss_v     <= 1'b1;
                    sin_q     <= lut[theta[kt][PHASE_WIDTH-1 -: LUT_ADDR_WIDTH]];
                    amp_q     <= ampl[kt];
                    theta[kt] <= theta[kt] + delta[kt];
                    k         <= k + NT_W'(1);
                    if (last) begin
                        dcnt  <= '0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    dcnt <= dcnt + 2'd1;
                    if (dcnt == 2'd3) begin
                        bus.o_dds_signal <= reduced;
                        bus.o_dds_valid  <= 1'b1;
                        state            <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multi_tone_dds.sv
// Directed self-checking bench for multi_tone_dds (8 tones, 16-bit samples).
module tb_multi_tone_dds;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    multi_tone_dds_if bus ();

    multi_tone_dds dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] sel, input int idx, input logic [31:0] data);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_sel  = sel;
        bus.i_wr_idx  = 3'(idx);
        bus.i_wr_data = data;
        tick();
        bus.i_wr_en   = 1'b0;
    endtask

    task automatic frame(output longint sig, output int lat);
        bus.i_sample_en = 1'b1;
        tick();
        bus.i_sample_en = 1'b0;
        lat = -1;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (bus.o_dds_valid) begin
                lat = j;
                break;
            end
        end
        sig = longint'($signed(bus.o_dds_signal));
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        longint s;
        int     l;
        int     bad_lat;
        int     nv;
        int     vat;
        longint drop;
        longint exp_two;
`ifdef DDS_SAT_EN
        exp_two = 32767;
`else
        exp_two = -4;
`endif
        rst             = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_num_tones = '0;
        bus.i_wr_en     = 1'b0;
        bus.i_wr_sel    = '0;
        bus.i_wr_idx    = '0;
        bus.i_wr_data   = '0;
        bus.i_sample_en = 1'b0;
        tick();
        tick();
        check("rst_sig", longint'(bus.o_dds_signal), 0);
        check("rst_valid", longint'(bus.o_dds_valid), 0);
        check("rst_busy", longint'(bus.o_busy), 0);
        check("rst_overrun", longint'(bus.o_overrun), 0);
        check("rst_wr_drop", longint'(bus.o_wr_drop), 0);
        rst = 1'b0;
        tick();

        // single tone at 90 degrees
        bus.i_num_tones = 4'd1;
        wr(2'd0, 0, 32'h4000_0000);
        wr(2'd2, 0, 32'h0000_7FFF);
        wr(2'd1, 0, 32'h0);
        bus.i_start = 1'b1;
        frame(s, l);
        check("single_lat", l, 5);
        check("single_sig", s, 32766);
        frame(s, l);
        check("single_repeat", s, 32766);

        bus.i_num_tones = 4'd0;
        frame(s, l);
        check("zero_lat", l, 4);
        check("zero_sig", s, 0);

        // phase stepping one LUT entry per frame
        bus.i_num_tones = 4'd1;
        wr(2'd0, 0, 32'h0);
        wr(2'd1, 0, 32'h0100_0000);
        bad_lat = 0;
        for (int f = 1; f <= 257; f++) begin
            frame(s, l);
            if (l != 5) bad_lat++;
            if (f == 1)   check("step_f1", s, 0);
            if (f == 2)   check("step_f2", s, 803);
            if (f == 65)  check("step_f65", s, 32766);
            if (f == 193) check("step_f193", s, -32767);
            if (f == 257) check("step_f257", s, 0);
        end
        check("step_lat_errs", bad_lat, 0);

        // two tones summed beyond full scale
        wr(2'd0, 0, 32'h4000_0000);
        wr(2'd1, 0, 32'h0);
        wr(2'd0, 1, 32'h4000_0000);
        wr(2'd1, 1, 32'h0);
        wr(2'd2, 1, 32'h0000_7FFF);
        bus.i_num_tones = 4'd2;
        frame(s, l);
        check("two_lat", l, 6);
        check("two_sig", s, exp_two);

        bus.i_start     = 1'b0;
        bus.i_sample_en = 1'b1;
        tick();
        bus.i_sample_en = 1'b0;
        nv = 0;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (bus.o_dds_valid) nv++;
        end
        check("nostart_valids", nv, 0);
        check("nostart_busy", longint'(bus.o_busy), 0);
        bus.i_start = 1'b1;

        bus.i_num_tones = 4'd15;
        frame(s, l);
        check("clamp_lat", l, 12);
        check("clamp_sig", s, exp_two);
        check("pre_overrun", longint'(bus.o_overrun), 0);

        // overrun strobe and dropped write inside one frame
        bus.i_num_tones = 4'd8;
        bus.i_sample_en = 1'b1;
        tick();
        bus.i_sample_en = 1'b0;
        nv   = 0;
        vat  = -1;
        drop = 0;
        for (int j = 1; j <= 20; j++) begin
            if (j == 3) bus.i_sample_en = 1'b1;
            if (j == 5) begin
                bus.i_wr_en   = 1'b1;
                bus.i_wr_sel  = 2'd2;
                bus.i_wr_idx  = 3'd0;
                bus.i_wr_data = 32'h0;
            end
            tick();
            bus.i_sample_en = 1'b0;
            bus.i_wr_en     = 1'b0;
            if (bus.o_dds_valid) begin
                nv++;
                vat = j;
            end
            if (j == 5) drop = longint'(bus.o_wr_drop);
        end
        check("ovr_valids", nv, 1);
        check("ovr_lat", vat, 12);
        check("ovr_flag", longint'(bus.o_overrun), 1);
        check("ovr_wr_drop", drop, 1);
        bus.i_num_tones = 4'd1;
        frame(s, l);
        check("dropped_keeps_ampl", s, 32766);

        // reset in the middle of a frame
        bus.i_num_tones = 4'd8;
        bus.i_sample_en = 1'b1;
        tick();
        bus.i_sample_en = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nv = 0;
        for (int j = 0; j < 15; j++) begin
            tick();
            if (bus.o_dds_valid) nv++;
        end
        check("midrst_valids", nv, 0);
        check("midrst_sig", longint'(bus.o_dds_signal), 0);
        check("midrst_busy", longint'(bus.o_busy), 0);
        check("midrst_overrun", longint'(bus.o_overrun), 0);
        check("midrst_wr_drop", longint'(bus.o_wr_drop), 0);
        bus.i_num_tones = 4'd1;
        frame(s, l);
        check("post_rst_lat", l, 5);
        check("post_rst_sig", s, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
